// File: rtl/timebase_pkg.sv
// Shared timebase definitions: countdown FSM state encodings and default sizing
// for the 1us/1ms timer chain running on the 20MHz system clock.
package timebase_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int CLK_HZ     = 20_000_000;
  localparam int MS_DIV_DEF = 1000;
  localparam int MS_W_DEF   = 10;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 1us -> 1ms divider: counts tick_1us pulses 0..MS_DIV-1 and emits a
// registered one-cycle ms_tick on each wrap back to 0.
module tick_prescaler
  import timebase_pkg::*;
#(
  parameter int MS_DIV = MS_DIV_DEF,
  parameter int MS_W   = MS_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_1us,
  output logic ms_tick
);

  localparam logic [MS_W-1:0] LAST = MS_W'(MS_DIV - 1);

  logic [MS_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      ms_tick <= 1'b0;
    end else if (tick_1us) begin
      if (cnt == LAST) begin
        cnt     <= '0;
        ms_tick <= 1'b1;
      end else begin
        cnt     <= cnt + MS_W'(1);
        ms_tick <= 1'b0;
      end
    end else begin
      ms_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/us_tick_timer.sv
// Programmable one-shot/periodic microsecond countdown with free-running 1ms tick.
// Optional freeze input enabled by defining US_TIMER_PAUSE_EN.
module us_tick_timer
  import timebase_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int MS_DIV = MS_DIV_DEF,
  parameter int MS_W   = MS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1us,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] load_val,
`ifdef US_TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic             busy,
  output logic             expire,
  output logic [CNT_W-1:0] remaining,
  output logic             ms_tick
);

  // state   | meaning
  // --------+--------------------------------------------------------------
  // ST_IDLE | no countdown; remaining=0; start may fire a zero-length shot
  // ST_RUN  | counting tick_1us down from the latched period; busy=1

  logic             pause_act;
  logic             cnt_tick;
  state_t           state;
  logic [CNT_W-1:0] period_q;
  logic             periodic_q;

`ifdef US_TIMER_PAUSE_EN
  assign pause_act = pause;
`else
  assign pause_act = 1'b0;
`endif

  assign cnt_tick = tick_1us & ~pause_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      expire     <= 1'b0;
      remaining  <= '0;
      period_q   <= '0;
      periodic_q <= 1'b0;
    end else begin
      expire <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!stop && start) begin
            if (load_val != '0) begin
              state      <= ST_RUN;
              busy       <= 1'b1;
              remaining  <= load_val;
              period_q   <= load_val;
              periodic_q <= periodic;
            end else begin
              expire <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // stop beats start beats tick; the losers of a collision are dropped
          if (stop) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            remaining <= '0;
          end else if (start) begin
            if (load_val != '0) begin
              remaining  <= load_val;
              period_q   <= load_val;
              periodic_q <= periodic;
            end else begin
              expire    <= 1'b1;
              state     <= ST_IDLE;
              busy      <= 1'b0;
              remaining <= '0;
            end
          end else if (cnt_tick) begin
            if (remaining > CNT_W'(1)) begin
              remaining <= remaining - CNT_W'(1);
            end else if (remaining == CNT_W'(1)) begin
              expire <= 1'b1;
              if (periodic_q) begin
                remaining <= period_q;
              end else begin
                remaining <= '0;
                state     <= ST_IDLE;
                busy      <= 1'b0;
              end
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          remaining <= '0;
        end
      endcase
    end
  end

  tick_prescaler #(
    .MS_DIV (MS_DIV),
    .MS_W   (MS_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_1us (tick_1us),
    .ms_tick  (ms_tick)
  );

endmodule

// File: tb/tb_us_tick_timer.sv
// Bench for us_tick_timer: 1us ticks every 20 clk, reference model checked every
// cycle plus directed literal checks. Define US_TIMER_PAUSE_EN to cover pause.
`timescale 1ns/1ps
module tb_us_tick_timer;

  localparam int CNT_W  = 16;
  localparam int MS_DIV = 1000;
  localparam int TICK_P = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tick_1us = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             periodic = 1'b0;
  logic             pause = 1'b0;
  logic [CNT_W-1:0] load_val = '0;
  logic             busy, expire, ms_tick;
  logic [CNT_W-1:0] remaining;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_exp = 0, last_exp = 0, prev_exp = 0;
  int n_ms = 0, last_ms = 0, ms_gap = 0;
  int n_tick = 0, n_busy = 0;

  logic             m_run, m_exp, m_perd, m_ms;
  logic [CNT_W-1:0] m_rem, m_per;
  int               m_tc;

  us_tick_timer #(.CNT_W(CNT_W), .MS_DIV(MS_DIV), .MS_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1us  (tick_1us),
    .start     (start),
    .stop      (stop),
    .periodic  (periodic),
    .load_val  (load_val),
`ifdef US_TIMER_PAUSE_EN
    .pause     (pause),
`endif
    .busy      (busy),
    .expire    (expire),
    .remaining (remaining),
    .ms_tick   (ms_tick)
  );

  always #25 clk = ~clk;

  // upstream 1us stage: one-cycle pulse every TICK_P clocks
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      tick_1us = (ph == TICK_P - 1);
      ph = (ph == TICK_P - 1) ? 0 : ph + 1;
    end
  end

  // reference model: timer as "run flag + us left", ms_tick from total tick count
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_rem <= '0; m_per <= '0; m_perd <= 1'b0;
      m_exp <= 1'b0; m_ms <= 1'b0; m_tc <= 0;
    end else begin
      m_exp <= 1'b0;
      if (stop) begin
        if (m_run) begin m_run <= 1'b0; m_rem <= '0; end
      end else if (start) begin
        if (load_val == 0) begin
          m_exp <= 1'b1; m_run <= 1'b0; m_rem <= '0;
        end else begin
          m_run <= 1'b1; m_rem <= load_val; m_per <= load_val; m_perd <= periodic;
        end
      end else if (m_run && tick_1us && !pause) begin
        if (m_rem == 1) begin
          m_exp <= 1'b1;
          if (m_perd) m_rem <= m_per;
          else begin m_rem <= '0; m_run <= 1'b0; end
        end else begin
          m_rem <= m_rem - 1'b1;
        end
      end
      if (tick_1us) begin
        m_tc <= m_tc + 1;
        m_ms <= ((m_tc + 1) % MS_DIV) == 0;
      end else begin
        m_ms <= 1'b0;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (expire) begin n_exp <= n_exp + 1; prev_exp <= last_exp; last_exp <= cyc; end
    if (ms_tick) begin n_ms <= n_ms + 1; ms_gap <= cyc - last_ms; last_ms <= cyc; end
    if (tick_1us) n_tick <= n_tick + 1;
    if (busy) n_busy <= n_busy + 1;
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // one clock: compare against the model mid-cycle, then land 2ns after the next edge
  task automatic step();
    @(negedge clk);
    n_vec++;
    if (busy !== m_run || expire !== m_exp || remaining !== m_rem || ms_tick !== m_ms) begin
      n_err++;
      $display("FAIL model cycle %0d: busy/expire/remaining/ms_tick got %b/%b/%0d/%b expected %b/%b/%0d/%b",
               cyc, busy, expire, remaining, ms_tick, m_run, m_exp, m_rem, m_ms);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic align_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * TICK_P; i++) begin
      step();
      if (tick_1us) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] v, input logic per);
    start = 1'b1; load_val = v; periodic = per;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic wait_exp(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (n_exp >= target) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    bit ok;
    int c0, e0, b0, m0, t0;

    steps(3);
    check("rst_busy", busy, 0);
    check("rst_expire", expire, 0);
    check("rst_remaining", remaining, 0);
    check("rst_ms_tick", ms_tick, 0);
    rst_n = 1'b1;
    steps(2);

    // 1: one-shot of 5 us
    e0 = n_exp;
    align_tick(ok); check("t1_align", ok, 1);
    step();
    c0 = cyc;
    pulse_start(5, 1'b0);
    check("t1_rem_load", remaining, 5);
    check("t1_busy", busy, 1);
    wait_exp(e0 + 1, 150, ok); check("t1_expire_seen", ok, 1);
    check("t1_latency", last_exp - c0, 100);
    check("t1_busy_after", busy, 0);
    check("t1_rem_after", remaining, 0);
    steps(40);
    check("t1_single_expire", n_exp - e0, 1);

    // 2: periodic 3 us, stop after the second expire
    e0 = n_exp;
    align_tick(ok); check("t2_align", ok, 1);
    step();
    c0 = cyc;
    pulse_start(3, 1'b1);
    wait_exp(e0 + 1, 100, ok); check("t2_expire1_seen", ok, 1);
    check("t2_latency1", last_exp - c0, 60);
    wait_exp(e0 + 2, 100, ok); check("t2_expire2_seen", ok, 1);
    check("t2_period", last_exp - prev_exp, 60);
    check("t2_busy_running", busy, 1);
    pulse_stop();
    check("t2_busy_stopped", busy, 0);
    steps(100);
    check("t2_no_third_expire", n_exp - e0, 2);

    // 3: zero-length shot, then retrigger at remaining==2
    e0 = n_exp; b0 = n_busy;
    pulse_start(0, 1'b0);
    steps(3);
    check("t3_zero_expire", n_exp - e0, 1);
    check("t3_zero_never_busy", n_busy - b0, 0);
    pulse_start(5, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (remaining == 2) begin ok = 1'b1; break; end
      step();
    end
    check("t3_reach_rem2", ok, 1);
    e0 = n_exp;
    pulse_start(10, 1'b0);
    check("t3_retrigger_rem", remaining, 10);
    check("t3_retrigger_busy", busy, 1);
    steps(2);
    check("t3_retrigger_no_expire", n_exp - e0, 0);
    pulse_stop();

    // 4: collisions
    pulse_start(8, 1'b0);
    steps(5);
    e0 = n_exp;
    align_tick(ok); check("t4_align1", ok, 1);
    stop = 1'b1; start = 1'b1; load_val = 7;
    step();
    stop = 1'b0; start = 1'b0;
    check("t4_collide_busy", busy, 0);
    check("t4_collide_rem", remaining, 0);
    check("t4_collide_no_expire", n_exp - e0, 0);
    align_tick(ok); check("t4_align2", ok, 1);
    pulse_start(7, 1'b0);
    check("t4_start_tick_rem", remaining, 7);
    pulse_stop();

    // 5: ms_tick over 3000 ticks from a fresh reset, then reset mid-run
    rst_n = 1'b0;
    steps(2);
    rst_n = 1'b1;
    m0 = n_ms; t0 = n_tick;
    ok = 1'b0;
    for (int i = 0; i < 61000; i++) begin
      step();
      if (n_tick - t0 >= 3000) begin ok = 1'b1; break; end
    end
    check("t5_ticks_seen", ok, 1);
    steps(3);
    check("t5_ms_count", n_ms - m0, 3);
    check("t5_ms_gap", ms_gap, 20000);

    pulse_start(50, 1'b0);
    steps(300);
    check("t5_running_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_expire", expire, 0);
    check("t5_rst_remaining", remaining, 0);
    check("t5_rst_ms_tick", ms_tick, 0);
    e0 = n_exp;
    step();
    rst_n = 1'b1;
    steps(1200);
    check("t5_no_expire_after_rst", n_exp - e0, 0);
    check("t5_idle_after_rst", busy, 0);

`ifdef US_TIMER_PAUSE_EN
    // 6: pause across two ticks stretches a 4 us shot to the 6th tick
    e0 = n_exp;
    align_tick(ok); check("t6_align", ok, 1);
    step();
    c0 = cyc;
    pulse_start(4, 1'b0);
    steps(29);
    pause = 1'b1;
    steps(40);
    check("t6_paused_busy", busy, 1);
    check("t6_paused_rem", remaining, 3);
    pause = 1'b0;
    wait_exp(e0 + 1, 150, ok); check("t6_expire_seen", ok, 1);
    check("t6_latency", last_exp - c0, 120);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
